// File: rtl/arb_requester.sv
// arb_requester: queues burst commands, requests the fixed-priority arbiter and
// streams one beat per granted cycle. Define ARB_REQUESTER_TIMEOUT_EN for the REQ watchdog.
module arb_requester #(
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_ready,
    output logic             req,
    input  logic             gnt,
    output logic             beat_valid,
    output logic [LEN_W-1:0] beat_idx,
    output logic             beat_last,
    output logic             done,
    output logic             abort,
    output logic             timeout,
    output logic             busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_idx_q, beat_idx_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic [LEN_W-1:0] mem_q [DEPTH];
    logic [LEN_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

`ifdef ARB_REQUESTER_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
`endif

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign cmd_ready = (count_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_idx_d = beat_idx_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
`ifdef ARB_REQUESTER_TIMEOUT_EN
        wait_d     = wait_q;
        timeout_d  = 1'b0;
`endif

        if (push) begin
            mem_d[wr_ptr_q] = cmd_len;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d    = S_REQ;
                    len_d      = mem_q[rd_ptr_q];
                    beat_idx_d = '0;
`ifdef ARB_REQUESTER_TIMEOUT_EN
                    wait_d     = '0;
`endif
                end
            end
            S_REQ: begin
                if (gnt) begin
                    state_d = S_XFER;
                end
`ifdef ARB_REQUESTER_TIMEOUT_EN
                else if (wait_q == WAIT_MAX) begin
                    state_d   = S_GAP;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            S_XFER: begin
                if (gnt) begin
                    if (beat_idx_q == len_q) begin
                        state_d = S_GAP;
                        done_d  = 1'b1;
                    end else begin
                        beat_idx_d = beat_idx_q + 1'b1;
                    end
                end else if (beat_idx_q != '0) begin
                    // Grant lost mid-burst; a low gnt on the first XFER cycle is just grant latency.
                    state_d = S_GAP;
                    abort_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_d = (state_d == S_REQ) || (state_d == S_XFER);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            beat_idx_q <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef ARB_REQUESTER_TIMEOUT_EN
            wait_q     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            beat_idx_q <= beat_idx_d;
            req_q      <= req_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef ARB_REQUESTER_TIMEOUT_EN
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign req        = req_q;
    assign done       = done_q;
    assign abort      = abort_q;
    assign beat_idx   = beat_idx_q;
    assign beat_valid = (state_q == S_XFER) && gnt;
    assign beat_last  = beat_valid && (beat_idx_q == len_q);
    assign busy       = (state_q != S_IDLE) || (count_q != '0);

`ifdef ARB_REQUESTER_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    // Without the watchdog TIMEOUT has no effect; the term folds to constant 0.
    assign timeout = 1'b0 && (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: cycle vector table, burst table, and
// hand-written corner sequences with a beat scoreboard.
module tb_arb_requester;

    localparam int LEN_W   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             gnt = 1'b0;
    logic             cmd_ready, req, beat_valid, beat_last, done, abort, timeout, busy;
    logic [LEN_W-1:0] beat_idx;
    logic             req0 = 1'b0;
    int               gmode = 0;

    arb_requester #(.LEN_W(LEN_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_len(cmd_len),
        .cmd_ready(cmd_ready), .req(req), .gnt(gnt), .beat_valid(beat_valid),
        .beat_idx(beat_idx), .beat_last(beat_last), .done(done), .abort(abort),
        .timeout(timeout), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0, abort_cnt = 0, tmo_cnt = 0, beat_cnt = 0;

    typedef struct packed {
        logic [LEN_W-1:0] idx;
        logic             last;
    } beat_t;
    beat_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_beats(input int len, input int n);
        for (int j = 0; j < n; j++) begin
            beat_t e;
            e.idx  = LEN_W'(j);
            e.last = (j == len);
            sb.push_back(e);
        end
    endtask

    // gmode 1: arbiter grants one cycle after req; gmode 2: req0 has priority.
    task automatic tick();
        logic pr, pr0;
        pr  = req;
        pr0 = req0;
        @(posedge clock);
        #1;
        case (gmode)
            1: gnt = pr;
            2: gnt = pr && !pr0;
            default: ;
        endcase
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int k;
        k = 0;
        while (busy && k < maxc) begin
            tick();
            k++;
        end
        check(name, busy, 0);
    endtask

    logic prev_done = 1'b0, prev_abort = 1'b0, prev_tmo = 1'b0;
    always @(negedge clock) begin
        if (!reset) begin
            if (beat_valid) begin
                beat_cnt++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got beat idx %0d, expected no beat", beat_idx);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("beat_idx", beat_idx, e.idx);
                    check("beat_last", beat_last, e.last);
                end
            end
            if (done || abort || timeout)
                check("pulse_exclusive", int'(done) + int'(abort) + int'(timeout), 1);
            if (done)    begin check("done_one_cycle", prev_done, 0);  done_cnt++;  end
            if (abort)   begin check("abort_one_cycle", prev_abort, 0); abort_cnt++; end
            if (timeout) begin check("tmo_one_cycle", prev_tmo, 0);   tmo_cnt++;   end
        end
        prev_done  = done;
        prev_abort = abort;
        prev_tmo   = timeout;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic cv; logic [LEN_W-1:0] len; logic g;
        logic req; logic bv; logic [LEN_W-1:0] idx; logic last; logic done; logic busy; logic rdy;
    } vec_t;
    vec_t vt[10];

    typedef struct { int len; int exp_beats; } burst_t;
    burst_t bt[4];

    int fl[5];
    int d0, a0, b0, t0, held;

    initial begin
        //          cv    len   g     req   bv    idx   last  done  busy  rdy
        vt[0] = '{1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[1] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[2] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[3] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[4] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[5] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[6] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[7] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[8] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[9] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        bt[0] = '{0, 1};
        bt[1] = '{15, 16};
        bt[2] = '{5, 6};
        bt[3] = '{1, 2};
        fl = '{1, 2, 0, 3, 5};

        // Reset state
        #3;
        check("rst_req", req, 0);
        check("rst_beat_valid", beat_valid, 0);
        check("rst_done", done, 0);
        check("rst_abort", abort, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_beat_idx", beat_idx, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single 4-beat command, grant one cycle behind req
        gmode = 0;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = vt[i].cv;
            cmd_len   = vt[i].len;
            gnt       = vt[i].g;
            if (vt[i].cv) expect_beats(int'(vt[i].len), int'(vt[i].len) + 1);
            #2;
            check("vec_req", req, vt[i].req);
            check("vec_beat_valid", beat_valid, vt[i].bv);
            if (vt[i].bv) check("vec_beat_idx", beat_idx, vt[i].idx);
            check("vec_beat_last", beat_last, vt[i].last);
            check("vec_done", done, vt[i].done);
            check("vec_busy", busy, vt[i].busy);
            check("vec_cmd_ready", cmd_ready, vt[i].rdy);
            tick();
        end
        cmd_valid = 1'b0;
        gnt = 1'b0;

        // Burst lengths including the full 2^LEN_W burst
        gmode = 1;
        for (int i = 0; i < 4; i++) begin
            b0 = beat_cnt;
            d0 = done_cnt;
            cmd_valid = 1'b1;
            cmd_len   = LEN_W'(bt[i].len);
            expect_beats(bt[i].len, bt[i].len + 1);
            tick();
            cmd_valid = 1'b0;
            wait_idle("burst_idle", 100);
            check("burst_beats", beat_cnt - b0, bt[i].exp_beats);
            check("burst_done", done_cnt - d0, 1);
        end

        // FIFO fill while the head command waits for a grant
        gmode = 0;
        gnt = 1'b0;
        cmd_valid = 1'b1;
        cmd_len = 4'd2;
        expect_beats(2, 3);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_len = LEN_W'(fl[i]);
            #2;
            check("fill_cmd_ready", cmd_ready, (i < 4));
            check("fill_busy", busy, 1);
            if (i < 4) expect_beats(fl[i], fl[i] + 1);
            tick();
        end
        cmd_valid = 1'b0;
        #2;
        check("full_cmd_ready", cmd_ready, 0);
        check("full_req", req, 1);
        d0 = done_cnt;
        gmode = 1;
        wait_idle("fill_drain", 300);
        check("fill_dones", done_cnt - d0, 5);
        check("fill_sb_empty", sb.size(), 0);

        // Grant lost after beat 2 of an 8-beat burst, next command follows
        a0 = abort_cnt;
        d0 = done_cnt;
        cmd_valid = 1'b1;
        cmd_len = 4'd7;
        expect_beats(7, 3);
        tick();
        cmd_len = 4'd1;
        expect_beats(1, 2);
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        gnt = 1'b0;
        #2;
        check("loss_no_beat", beat_valid, 0);
        tick();
        #2;
        check("loss_abort", abort, 1);
        check("loss_no_done", done, 0);
        check("loss_req_low", req, 0);
        tick();
        #2;
        check("loss_abort_clear", abort, 0);
        check("loss_gap_req_low", req, 0);
        wait_idle("loss_idle", 100);
        check("loss_abort_cnt", abort_cnt - a0, 1);
        check("loss_done_cnt", done_cnt - d0, 1);
        check("loss_sb_empty", sb.size(), 0);

        // Long wait in REQ with no grant
        gmode = 0;
        gnt = 1'b0;
        t0 = tmo_cnt;
        cmd_valid = 1'b1;
        cmd_len = 4'd0;
`ifdef ARB_REQUESTER_TIMEOUT_EN
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        repeat (16) tick();
        #2;
        check("tmo_not_yet", timeout, 0);
        check("tmo_req_still", req, 1);
        tick();
        #2;
        check("tmo_pulse", timeout, 1);
        check("tmo_req_low", req, 0);
        tick();
        #2;
        check("tmo_clear", timeout, 0);
        wait_idle("tmo_idle", 20);
        check("tmo_cnt", tmo_cnt - t0, 1);
`else
        expect_beats(0, 1);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        held = 0;
        repeat (120) begin
            if (req === 1'b1 && timeout === 1'b0) held++;
            tick();
        end
        check("notmo_req_held", held, 120);
        check("notmo_cnt", tmo_cnt - t0, 0);
        gmode = 1;
        wait_idle("notmo_idle", 20);
`endif

        // Asynchronous reset at beat_idx 1 with two commands queued
        gmode = 1;
        cmd_valid = 1'b1;
        cmd_len = 4'd3;
        expect_beats(3, 2);
        tick();
        cmd_len = 4'd5;
        tick();
        cmd_len = 4'd2;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        d0 = done_cnt;
        a0 = abort_cnt;
        @(negedge clock);
        #1;
        reset = 1'b1;
        gmode = 0;
        gnt = 1'b0;
        #1;
        check("rstx_req", req, 0);
        check("rstx_busy", busy, 0);
        check("rstx_cmd_ready", cmd_ready, 1);
        check("rstx_beat_valid", beat_valid, 0);
        check("rstx_done", done, 0);
        check("rstx_abort", abort, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (8) tick();
        check("rstx_stay_idle", busy, 0);
        check("rstx_no_done", done_cnt - d0, 0);
        check("rstx_no_abort", abort_cnt - a0, 0);
        check("rstx_sb_empty", sb.size(), 0);

        // Higher-priority requester holds the bus, then releases it
        gmode = 2;
        req0 = 1'b1;
        d0 = done_cnt;
        cmd_valid = 1'b1;
        cmd_len = 4'd2;
        expect_beats(2, 3);
        tick();
        cmd_valid = 1'b0;
        tick();
        held = 0;
        repeat (10) begin
            if (req === 1'b1 && beat_valid === 1'b0) held++;
            tick();
        end
        check("pair_held_in_req", held, 10);
        req0 = 1'b0;
        wait_idle("pair_idle", 50);
        check("pair_done", done_cnt - d0, 1);

        check("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
